video_crtc_gen2: RTL and testbench

- Parametrised, 6545-class successor to the existing CRTC timing core.
- Generates h/v sync, display enable, refresh address (MA) and raster address (RA) from programmed timing values.
- Adds hardware cursor with blink, programmable DE/cursor skew, and configurable counter widths.
- Sits between the CRTC register block (which supplies all timing values as ports) and the video pixel/character fetch path. Advances one character per clk_en_i.

---
 rtl/video_pkg.sv | 18 +
 rtl/video_sync_pulse.sv | 42 ++++
 rtl/video_crtc_gen2.sv | 203 ++++++++++++++++++++
 tb/tb_video_crtc_gen2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the gen2 CRTC timing core.
// Frame-state enum, cursor blink modes and the skew pipeline depth.
package video_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        ADJUST      = 2'd1,
        FRAME_START = 2'd2
    } frame_state_t;

    localparam logic [1:0] BLINK_STEADY = 2'b00;
    localparam logic [1:0] BLINK_OFF    = 2'b01;
    localparam logic [1:0] BLINK_16     = 2'b10;
    localparam logic [1:0] BLINK_32     = 2'b11;

    localparam int SKEW_DEPTH = 3;

endpackage

// File: rtl/video_sync_pulse.sv
// video_sync_pulse: start-match / width counter shared by hsync and vsync.
// Ports: i_clk, i_rst_n, i_cnt_en (count strobe), i_match, i_width -> o_pulse.
module video_sync_pulse #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cnt_en,
    input  logic             i_match,
    input  logic [WIDTH-1:0] i_width,
    output logic             o_pulse
);

    localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

    logic           r_active;
    logic [WIDTH:0] r_left;
    logic [WIDTH:0] w_len;

    // A programmed width of zero selects the full 2^WIDTH span.
    assign w_len   = (i_width == '0) ? FULL : {1'b0, i_width};
    // The matching unit itself is the first unit of the pulse.
    assign o_pulse = r_active | i_match;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_left   <= '0;
        end else if (i_cnt_en) begin
            if (r_active) begin
                r_left <= r_left - ONE;
                if (r_left == ONE)
                    r_active <= 1'b0;
            end else if (i_match) begin
                r_left   <= w_len - ONE;
                r_active <= (w_len != ONE);
            end
        end
    end

endmodule

// File: rtl/video_crtc_gen2.sv
// video_crtc_gen2: 6545-class CRTC timing core with cursor, blink and skew.
// Inputs: programmed timing/cursor values; outputs: syncs, DE, cursor, MA, RA.
module video_crtc_gen2
    import video_pkg::*;
#(
    parameter int MA_WIDTH   = 14,
    parameter int RA_WIDTH   = 5,
    parameter int H_WIDTH    = 8,
    parameter int V_WIDTH    = 7,
    parameter int SYNC_WIDTH = 4
) (
    input  logic                  wb_clock_i,
    input  logic                  reset_ni,
    input  logic                  clk_en_i,
    input  logic [H_WIDTH-1:0]    h_total_i,
    input  logic [H_WIDTH-1:0]    h_displayed_i,
    input  logic [H_WIDTH-1:0]    h_sync_pos_i,
    input  logic [SYNC_WIDTH-1:0] h_sync_width_i,
    input  logic [SYNC_WIDTH-1:0] v_sync_width_i,
    input  logic [V_WIDTH-1:0]    v_total_i,
    input  logic [RA_WIDTH-1:0]   v_adjust_i,
    input  logic [V_WIDTH-1:0]    v_displayed_i,
    input  logic [V_WIDTH-1:0]    v_sync_pos_i,
    input  logic [RA_WIDTH-1:0]   max_scan_line_i,
    input  logic [RA_WIDTH-1:0]   cursor_start_i,
    input  logic [1:0]            cursor_blink_i,
    input  logic [RA_WIDTH-1:0]   cursor_end_i,
    input  logic [MA_WIDTH-1:0]   start_addr_i,
    input  logic [MA_WIDTH-1:0]   cursor_addr_i,
    input  logic [1:0]            de_skew_i,
    input  logic [1:0]            cursor_skew_i,
    output logic                  h_sync_o,
    output logic                  v_sync_o,
    output logic                  de_o,
    output logic                  cursor_o,
    output logic [MA_WIDTH-1:0]   ma_o,
    output logic [RA_WIDTH-1:0]   ra_o,
    output logic                  frame_start_o
);

    localparam logic [H_WIDTH-1:0]  H_ONE  = {{(H_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [V_WIDTH-1:0]  V_ONE  = {{(V_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RA_WIDTH-1:0] RA_ONE = {{(RA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MA_WIDTH-1:0] MA_ONE = {{(MA_WIDTH-1){1'b0}}, 1'b1};

    logic [H_WIDTH-1:0]    r_h_cnt;
    logic [RA_WIDTH-1:0]   r_ra;
    logic [V_WIDTH-1:0]    r_row;
    logic [MA_WIDTH-1:0]   r_ma;
    logic [MA_WIDTH-1:0]   r_row_base;
    frame_state_t          r_state;
    logic [4:0]            r_blink;
    logic                  r_vs_done;
    logic [SKEW_DEPTH-1:0] r_de_sr;
    logic [SKEW_DEPTH-1:0] r_cur_sr;

    logic                w_line_end;
    logic                w_row_end;
    logic                w_h_de;
    logic                w_v_de;
    logic                w_de_raw;
    logic                w_cur_raw;
    logic                w_blink_on;
    logic                w_adj_done;
    logic                w_frame_wrap;
    logic                w_base_upd;
    logic [MA_WIDTH-1:0] w_ma_inc;
    logic                w_hs_match;
    logic                w_vs_match;
    logic                w_hs;
    logic                w_vs;
    logic                w_de_sk;
    logic                w_cur_sk;

    // >= comparisons keep counters bounded when registers are lowered live.
    assign w_line_end = (r_h_cnt >= h_total_i);
    assign w_row_end  = w_line_end && (r_ra >= max_scan_line_i);
    assign w_h_de     = (r_h_cnt < h_displayed_i);
    assign w_v_de     = (r_row < v_displayed_i) && (r_state != ADJUST);
    assign w_de_raw   = w_h_de && w_v_de;
    assign w_ma_inc   = r_ma + MA_ONE;

    assign w_adj_done = (v_adjust_i == '0) || (r_ra >= v_adjust_i - RA_ONE);
    assign w_frame_wrap = w_line_end &&
        ((r_state == ADJUST) ? w_adj_done :
         (w_row_end && (r_row >= v_total_i) && (v_adjust_i == '0)));

    assign w_base_upd = (r_h_cnt == h_displayed_i - H_ONE) &&
                        (r_ra == max_scan_line_i);

    always_comb begin
        w_blink_on = 1'b1;
        case (cursor_blink_i)
            BLINK_STEADY: w_blink_on = 1'b1;
            BLINK_OFF:    w_blink_on = 1'b0;
            BLINK_16:     w_blink_on = (r_blink[3:0] < 4'd8);
            default:      w_blink_on = (r_blink < 5'd16);
        endcase
    end

    assign w_cur_raw = w_de_raw && (r_ma == cursor_addr_i) &&
                       (r_ra >= cursor_start_i) &&
                       (r_ra <= cursor_end_i) && w_blink_on;

    assign w_hs_match = (r_h_cnt == h_sync_pos_i);
    // The done latch limits vsync to one pulse per frame.
    assign w_vs_match = (r_row == v_sync_pos_i) && (r_ra == '0) && !r_vs_done;

    video_sync_pulse #(.WIDTH(SYNC_WIDTH)) u_hsync (
        .i_clk    (wb_clock_i),
        .i_rst_n  (reset_ni),
        .i_cnt_en (clk_en_i),
        .i_match  (w_hs_match),
        .i_width  (h_sync_width_i),
        .o_pulse  (w_hs)
    );

    video_sync_pulse #(.WIDTH(SYNC_WIDTH)) u_vsync (
        .i_clk    (wb_clock_i),
        .i_rst_n  (reset_ni),
        .i_cnt_en (clk_en_i && w_line_end),
        .i_match  (w_vs_match),
        .i_width  (v_sync_width_i),
        .o_pulse  (w_vs)
    );

    always_comb begin
        w_de_sk  = w_de_raw;
        w_cur_sk = w_cur_raw;
        case (de_skew_i)
            2'd0:    w_de_sk = w_de_raw;
            2'd1:    w_de_sk = r_de_sr[0];
            2'd2:    w_de_sk = r_de_sr[1];
            default: w_de_sk = r_de_sr[2];
        endcase
        case (cursor_skew_i)
            2'd0:    w_cur_sk = w_cur_raw;
            2'd1:    w_cur_sk = r_cur_sr[0];
            2'd2:    w_cur_sk = r_cur_sr[1];
            default: w_cur_sk = r_cur_sr[2];
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_h_cnt    <= '0;
            r_ra       <= '0;
            r_row      <= '0;
            r_ma       <= '0;
            r_row_base <= '0;
            r_state    <= NORMAL;
            r_blink    <= '0;
            r_vs_done  <= 1'b0;
            r_de_sr    <= '0;
            r_cur_sr   <= '0;
        end else if (clk_en_i) begin
            r_de_sr  <= {r_de_sr[SKEW_DEPTH-2:0], w_de_raw};
            r_cur_sr <= {r_cur_sr[SKEW_DEPTH-2:0], w_cur_raw};
            r_h_cnt  <= w_line_end ? '0 : r_h_cnt + H_ONE;
            if (w_base_upd)
                r_row_base <= w_ma_inc;
            if (w_line_end)
                r_ma <= w_base_upd ? w_ma_inc : r_row_base;
            else
                r_ma <= w_ma_inc;
            if (r_state == FRAME_START) begin
                r_blink <= r_blink + 5'd1;
                r_state <= NORMAL;
            end
            if (w_line_end) begin
                if (w_vs_match)
                    r_vs_done <= 1'b1;
                // Counters are rewound as FRAME_START is entered so that
                // its single character is already the frame's first one.
                if (w_frame_wrap) begin
                    r_state    <= FRAME_START;
                    r_row      <= '0;
                    r_ra       <= '0;
                    r_ma       <= start_addr_i;
                    r_row_base <= start_addr_i;
                    r_vs_done  <= 1'b0;
                end else if (r_state != ADJUST && w_row_end) begin
                    r_ra  <= '0;
                    r_row <= r_row + V_ONE;
                    if (r_row >= v_total_i)
                        r_state <= ADJUST;
                end else begin
                    r_ra <= r_ra + RA_ONE;
                end
            end
        end
    end

    // Reset forces every output low immediately, including combinational ones.
    assign h_sync_o      = reset_ni && w_hs;
    assign v_sync_o      = reset_ni && w_vs;
    assign de_o          = reset_ni && w_de_sk;
    assign cursor_o      = reset_ni && w_cur_sk;
    assign ma_o          = r_ma;
    assign ra_o          = r_ra;
    assign frame_start_o = reset_ni && clk_en_i && (r_state == FRAME_START);

endmodule

// File: tb/tb_video_crtc_gen2.sv
// tb_video_crtc_gen2: directed bench for the gen2 CRTC timing core.
// Drives timing setups and compares outputs against hand-derived values.
module tb_video_crtc_gen2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  h_total, h_disp, h_sp;
    logic [3:0]  h_sw, v_sw;
    logic [6:0]  v_total, v_disp, v_sp;
    logic [4:0]  v_adj, max_scan, cs, ce;
    logic [1:0]  blink, de_sk, cur_sk;
    logic [13:0] start_addr, cur_addr;

    logic        h_sync, v_sync, de, cursor, fs;
    logic [13:0] ma;
    logic [4:0]  ra;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    video_crtc_gen2 dut (
        .wb_clock_i     (clk),
        .reset_ni       (rst_n),
        .clk_en_i       (en),
        .h_total_i      (h_total),
        .h_displayed_i  (h_disp),
        .h_sync_pos_i   (h_sp),
        .h_sync_width_i (h_sw),
        .v_sync_width_i (v_sw),
        .v_total_i      (v_total),
        .v_adjust_i     (v_adj),
        .v_displayed_i  (v_disp),
        .v_sync_pos_i   (v_sp),
        .max_scan_line_i(max_scan),
        .cursor_start_i (cs),
        .cursor_blink_i (blink),
        .cursor_end_i   (ce),
        .start_addr_i   (start_addr),
        .cursor_addr_i  (cur_addr),
        .de_skew_i      (de_sk),
        .cursor_skew_i  (cur_sk),
        .h_sync_o       (h_sync),
        .v_sync_o       (v_sync),
        .de_o           (de),
        .cursor_o       (cursor),
        .ma_o           (ma),
        .ra_o           (ra),
        .frame_start_o  (fs)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_std();
        h_total = 8'd7;  h_disp = 8'd4;  h_sp = 8'd5;  h_sw = 4'd2;
        v_sw = 4'd1;     v_total = 7'd2; v_disp = 7'd2; v_sp = 7'd1;
        v_adj = 5'd1;    max_scan = 5'd1;
        cs = 5'd0;       ce = 5'd1;      blink = 2'b01;
        start_addr = 14'h0; cur_addr = 14'h5;
        de_sk = 2'd0;    cur_sk = 2'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit raw_de(int te);
        int h = te % 8;
        int l = (te / 8) % 7;
        return (h < 4) && (l < 4);
    endfunction

    function automatic bit raw_cur(int te);
        int h = te % 8;
        int l = (te / 8) % 7;
        return (h == 1) && (l == 2 || l == 3);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int h, l, f, te;
        cfg_std();
        h_sp = 8'd0;
        cur_addr = 14'h0;
        blink = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_hs", 32'(h_sync), 0);
        chk("rst_vs", 32'(v_sync), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_cur", 32'(cursor), 0);
        chk("rst_ma", 32'(ma), 0);
        chk("rst_ra", 32'(ra), 0);
        chk("rst_fs", 32'(fs), 0);

        // Basic timing: 8-char lines, 7-line frames, 56-clock period.
        cfg_std();
        do_reset();
        for (int t = 0; t < 120; t++) begin
            if (t > 0) step();
            h = t % 8;
            l = (t / 8) % 7;
            chk($sformatf("hs t=%0d", t), 32'(h_sync), 32'(h == 5 || h == 6));
            chk($sformatf("de t=%0d", t), 32'(de), 32'(h < 4 && l < 4));
            chk($sformatf("vs t=%0d", t), 32'(v_sync), 32'(l == 2));
            chk($sformatf("ra t=%0d", t), 32'(ra), 32'((l < 6) ? l % 2 : 0));
            chk($sformatf("ma t=%0d", t), 32'(ma), 32'(4 * (l / 2) + h));
            chk($sformatf("fs t=%0d", t), 32'(fs),
                32'(t > 0 && t % 56 == 0));
            chk($sformatf("cur_off t=%0d", t), 32'(cursor), 0);
        end

        // Sync width 0 means 16; zero displayed columns blanks the line.
        cfg_std();
        h_total = 8'd31; h_disp = 8'd0; h_sp = 8'd2; h_sw = 4'd0;
        do_reset();
        for (int t = 0; t < 41; t++) begin
            if (t > 0) step();
            h = t % 32;
            chk($sformatf("hs16 t=%0d", t), 32'(h_sync),
                32'(h >= 2 && h <= 17));
            chk($sformatf("de0 t=%0d", t), 32'(de), 0);
        end

        // No adjust lines: frame of 6 scan lines.
        cfg_std();
        v_adj = 5'd0;
        do_reset();
        for (int t = 0; t < 101; t++) begin
            if (t > 0) step();
            l = (t / 8) % 6;
            chk($sformatf("fs_noadj t=%0d", t), 32'(fs),
                32'(t > 0 && t % 48 == 0));
            chk($sformatf("ra_noadj t=%0d", t), 32'(ra), 32'(l % 2));
        end

        // Address wrap at the top of the 14-bit space.
        cfg_std();
        start_addr = 14'h3FF8;
        do_reset();
        for (int t = 0; t < 90; t++) begin
            if (t > 0) step();
            if (t == 56) chk("ma_start", 32'(ma), 32'h3FF8);
            if (t == 63) chk("ma_top", 32'(ma), 32'h3FFF);
            if (t == 72) chk("ma_row1", 32'(ma), 32'h3FFC);
            if (t == 76) chk("ma_wrap", 32'(ma), 32'h0000);
            if (t == 88) chk("ma_row2", 32'(ma), 32'h0000);
        end

        // 16-frame blink: on for frames 0-7, off for 8-15, on again at 16.
        cfg_std();
        blink = 2'b10;
        do_reset();
        for (int t = 0; t < 17 * 56; t++) begin
            if (t > 0) step();
            f = t / 56;
            h = t % 8;
            l = (t / 8) % 7;
            chk($sformatf("blink t=%0d", t), 32'(cursor),
                32'(h == 1 && (l == 2 || l == 3) && (f % 16) < 8));
        end

        // Start above end gives no cursor; then a one-line cursor.
        cfg_std();
        blink = 2'b00; cs = 5'd1; ce = 5'd0;
        do_reset();
        for (int t = 0; t < 112; t++) begin
            if (t > 0) step();
            chk($sformatf("cur_se t=%0d", t), 32'(cursor),
                32'(t >= 56 && t == 81));
            if (t == 55) ce = 5'd1;
        end

        // Skews: DE 2 chars late, cursor 1 char late, with enable gaps.
        cfg_std();
        blink = 2'b00; de_sk = 2'd2; cur_sk = 2'd1;
        do_reset();
        te = 0;
        chk("sk_de0", 32'(de), 0);
        chk("sk_cur0", 32'(cursor), 0);
        for (int i = 0; i < 150; i++) begin
            en = (i % 3 != 2);
            step();
            if (en) te++;
            chk($sformatf("sk_de i=%0d", i), 32'(de),
                32'(te >= 2 && raw_de(te - 2)));
            chk($sformatf("sk_cur i=%0d", i), 32'(cursor),
                32'(te >= 1 && raw_cur(te - 1)));
        end
        en = 1'b1;

        // Lowering h_total mid-line ends the line on the next char.
        cfg_std();
        h_total = 8'd63;
        do_reset();
        repeat (40) step();
        chk("lt_ma40", 32'(ma), 32'd40);
        chk("lt_ra0", 32'(ra), 0);
        h_total = 8'd7;
        step();
        chk("lt_ma_end", 32'(ma), 0);
        chk("lt_ra_end", 32'(ra), 1);
        step();
        chk("lt_ma_next", 32'(ma), 1);

        // Asynchronous reset in the middle of vsync.
        cfg_std();
        do_reset();
        for (int k = 0; k < 200 && !v_sync; k++) step();
        chk("vs_seen", 32'(v_sync), 1);
        repeat (3) step();
        chk("vs_pre", 32'(v_sync), 1);
        chk("de_pre", 32'(de), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_hs", 32'(h_sync), 0);
        chk("ar_vs", 32'(v_sync), 0);
        chk("ar_de", 32'(de), 0);
        chk("ar_cur", 32'(cursor), 0);
        chk("ar_ma", 32'(ma), 0);
        chk("ar_ra", 32'(ra), 0);
        chk("ar_fs", 32'(fs), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
